// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential 4-bit ALU.
package alu_pkg;

    localparam int ALU_OPW  = 4;
    localparam int ALU_RESW = 8;
    localparam int ALU_ITER = 4;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_MUL = 3'd1,
        ALU_MOD = 3'd2,
        ALU_AND = 3'd3,
        ALU_SUB = 3'd4,
        ALU_DIV = 3'd5,
        ALU_OR  = 3'd6,
        ALU_XOR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Ops that go through the multi-cycle shift engine
    function automatic logic alu_is_iter(alu_op_e op);
        return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// Command/response handshake bundle for alu_seq_unit.
// rsp_dz exists only when ALU_SEQ_DZ_ERR_EN is defined.
interface alu_seq_unit_if;
    import alu_pkg::*;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ALU_OPW-1:0]       cmd_a;
    logic [ALU_OPW-1:0]       cmd_b;
    alu_op_e                  cmd_op;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ALU_RESW-1:0]      rsp_result;
`ifdef ALU_SEQ_DZ_ERR_EN
    logic                     rsp_dz;
`endif

    // Requester side
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result
`ifdef ALU_SEQ_DZ_ERR_EN
      , input  rsp_dz
`endif
    );

    // ALU side
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result
`ifdef ALU_SEQ_DZ_ERR_EN
      , output rsp_dz
`endif
    );

endinterface

// File: rtl/alu_seq_iter.sv
// Shared shift-add multiplier / restoring divider, one bit per step.
// mode is captured at load: 0 = multiply (a*b), 1 = divide (a/b, a%b).
module alu_seq_iter
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic                mode,
    input  logic [ALU_OPW-1:0]  a,
    input  logic [ALU_OPW-1:0]  b,
    output logic [ALU_RESW-1:0] acc,
    output logic [ALU_OPW-1:0]  quot,
    output logic [ALU_OPW-1:0]  rem
);

    logic                div_q;
    logic [ALU_RESW-1:0] acc_q;
    logic [ALU_RESW-1:0] mcand_q;
    logic [ALU_OPW-1:0]  q_q;     // multiplier (mul) or dividend->quotient (div)
    logic [ALU_OPW-1:0]  rem_q;
    logic [ALU_OPW-1:0]  dvs_q;
    logic [ALU_OPW:0]    trial;

    // Partial remainder with the next dividend bit shifted in
    always_comb trial = {rem_q, q_q[ALU_OPW-1]};

    // One iteration per step; divide by zero falls out naturally (q=F, rem=a)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
        end else if (load) begin
            div_q   <= mode;
            acc_q   <= '0;
            mcand_q <= {{(ALU_RESW-ALU_OPW){1'b0}}, a};
            q_q     <= mode ? a : b;
            rem_q   <= '0;
            dvs_q   <= b;
        end else if (step) begin
            if (div_q) begin
                if (trial >= {1'b0, dvs_q}) begin
                    rem_q <= ALU_OPW'(trial - {1'b0, dvs_q});
                    q_q   <= {q_q[ALU_OPW-2:0], 1'b1};
                end else begin
                    rem_q <= trial[ALU_OPW-1:0];
                    q_q   <= {q_q[ALU_OPW-2:0], 1'b0};
                end
            end else begin
                if (q_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q <= mcand_q << 1;
                q_q     <= q_q >> 1;
            end
        end
    end

    assign acc  = acc_q;
    assign quot = q_q;
    assign rem  = rem_q;

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked sequential 4-bit ALU with 8-bit result.
// Optional divide-by-zero flag output enabled by ALU_SEQ_DZ_ERR_EN.
module alu_seq_unit
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_unit_if.slave bus
);

    alu_state_e          state_q, state_d;
    alu_op_e             op_q;
    logic [ALU_RESW-1:0] res_q;
    logic [2:0]          cnt_q;
    logic                accept, load, step, ready, valid;
    logic [ALU_RESW-1:0] simple_res;
    logic [ALU_RESW-1:0] eng_acc;
    logic [ALU_OPW-1:0]  eng_quot, eng_rem;

    // Single-cycle op results from the live command operands
    always_comb begin
        simple_res = '0;
        case (bus.cmd_op)
            ALU_ADD: simple_res = {4'h0, bus.cmd_a} + {4'h0, bus.cmd_b};
            ALU_SUB: simple_res = {4'h0, bus.cmd_a} - {4'h0, bus.cmd_b};
            ALU_AND: simple_res = {4'h0, bus.cmd_a & bus.cmd_b};
            ALU_OR:  simple_res = {4'h0, bus.cmd_a | bus.cmd_b};
            ALU_XOR: simple_res = {4'h0, bus.cmd_a ^ bus.cmd_b};
            default: simple_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and handshake/engine controls
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        valid   = 1'b0;
        accept  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept = 1'b1;
                    if (alu_is_iter(bus.cmd_op)) begin
                        load    = 1'b1;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                step = 1'b1;
                if (cnt_q == 3'd1) state_d = ST_DONE;
            end
            ST_DONE: begin
                valid = 1'b1;
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture command at accept; count down engine iterations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= ALU_ADD;
            res_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            op_q  <= bus.cmd_op;
            res_q <= simple_res;
            cnt_q <= alu_is_iter(bus.cmd_op) ? 3'(ALU_ITER) : 3'd0;
        end else if (step) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

`ifdef ALU_SEQ_DZ_ERR_EN
    logic dz_q;

    // Flag division by zero for the response being built
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dz_q <= 1'b0;
        else if (accept) dz_q <= (bus.cmd_op == ALU_DIV || bus.cmd_op == ALU_MOD) &&
                                 (bus.cmd_b == '0);
    end

    assign bus.rsp_dz = dz_q;
`endif

    alu_seq_iter u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .mode  (bus.cmd_op != ALU_MUL),
        .a     (bus.cmd_a),
        .b     (bus.cmd_b),
        .acc   (eng_acc),
        .quot  (eng_quot),
        .rem   (eng_rem)
    );

    // Engine registers are frozen outside BUSY, so this mux is stable in DONE
    always_comb begin
        case (op_q)
            ALU_MUL: bus.rsp_result = eng_acc;
            ALU_DIV: bus.rsp_result = {4'h0, eng_quot};
            ALU_MOD: bus.rsp_result = {4'h0, eng_rem};
            default: bus.rsp_result = res_q;
        endcase
    end

    assign bus.cmd_ready = ready;
    assign bus.rsp_valid = valid;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit.
module tb_alu_seq_unit;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_seq_unit_if bus ();

    alu_seq_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_dz(input string tag, input logic exp);
`ifdef ALU_SEQ_DZ_ERR_EN
        chk(tag, 32'(bus.rsp_dz), 32'(exp));
`else
        if (exp && tag.len() == 0) $display("dz %s", tag);
`endif
    endtask

    // Issue one command with rsp_ready high; check latency, result, return to IDLE
    task automatic do_cmd(input string tag, input alu_op_e op, input logic [3:0] a,
                          input logic [3:0] b, input logic [7:0] exp, input int lat,
                          input logic exp_dz);
        int n;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " lat"}, 32'(n), 32'(lat));
        chk({tag, " res"}, 32'(bus.rsp_result), 32'(exp));
        chk_dz({tag, " dz"}, exp_dz);
        @(posedge clk); #1;
        chk({tag, " rdy"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, " vld"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_op = ALU_ADD; bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst result", 32'(bus.rsp_result), 32'h00);
        chk_dz("rst dz", 1'b0);
        rst_n = 1'b1;

        do_cmd("add", ALU_ADD, 4'd9,  4'd7,  8'h10, 1, 1'b0);
        do_cmd("sub", ALU_SUB, 4'd2,  4'd5,  8'hFD, 1, 1'b0);
        do_cmd("xor", ALU_XOR, 4'hA,  4'h6,  8'h0C, 1, 1'b0);
        do_cmd("and", ALU_AND, 4'hC,  4'hA,  8'h08, 1, 1'b0);
        do_cmd("or",  ALU_OR,  4'h9,  4'h6,  8'h0F, 1, 1'b0);
        do_cmd("div", ALU_DIV, 4'd13, 4'd4,  8'h03, 5, 1'b0);
        do_cmd("mod", ALU_MOD, 4'd13, 4'd4,  8'h01, 5, 1'b0);
        do_cmd("div0", ALU_DIV, 4'd9, 4'd0,  8'h0F, 5, 1'b1);
        do_cmd("mod0", ALU_MOD, 4'd9, 4'd0,  8'h09, 5, 1'b1);

        // MUL with cmd_valid held high (and operands changed) through BUSY
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_op = ALU_MUL; bus.cmd_a = 4'd15; bus.cmd_b = 4'd15;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_op = ALU_ADD; bus.cmd_a = 4'd3; bus.cmd_b = 4'd3;
        for (int i = 1; i <= 4; i++) begin
            chk("mul busy rdy", 32'(bus.cmd_ready), 32'd0);
            chk("mul busy vld", 32'(bus.rsp_valid), 32'd0);
            if (i == 4) bus.cmd_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk("mul vld at 5", 32'(bus.rsp_valid), 32'd1);
        chk("mul res", 32'(bus.rsp_result), 32'hE1);
        chk_dz("mul dz", 1'b0);
        @(posedge clk); #1;
        chk("mul back idle", 32'(bus.cmd_ready), 32'd1);

        // Stall in DONE for 3 cycles with rsp_ready low
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_op = ALU_DIV; bus.cmd_a = 4'd13; bus.cmd_b = 4'd4;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall lat", 32'(n), 32'd5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall vld", 32'(bus.rsp_valid), 32'd1);
            chk("stall res", 32'(bus.rsp_result), 32'h03);
            chk("stall rdy", 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall done vld", 32'(bus.rsp_valid), 32'd0);
        chk("stall done rdy", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        chk("stall single hs", 32'(bus.rsp_valid), 32'd0);

        // Reset pulse in 2nd BUSY cycle of a MUL
        bus.cmd_valid = 1'b1; bus.cmd_op = ALU_MUL; bus.cmd_a = 4'd15; bus.cmd_b = 4'd15;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort rdy", 32'(bus.cmd_ready), 32'd1);
        chk("abort vld", 32'(bus.rsp_valid), 32'd0);
        chk("abort res", 32'(bus.rsp_result), 32'h00);
        chk_dz("abort dz", 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst_n = 1'b1;
            chk("abort no rsp", 32'(bus.rsp_valid), 32'd0);
        end
        do_cmd("mul post rst", ALU_MUL, 4'd7, 4'd6, 8'h2A, 5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
